// File: rtl/terminal_char_sender_if.sv
// Host/terminal signal bundle for terminal_char_sender.
// slave is the sender's view; master is the view of the environment
// (host write logic plus the terminal acknowledge line).
interface terminal_char_sender_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [6:0]    wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          timeout_err;
  logic          err_clr;
  logic [6:0]    term_data;
  logic          term_da;
  logic          term_rda;
  logic          busy;

  modport slave (
    input  wr_en, wr_data, err_clr, term_rda,
    output full, empty, count, overflow, timeout_err, term_data, term_da, busy
  );

  modport master (
    output wr_en, wr_data, err_clr, term_rda,
    input  full, empty, count, overflow, timeout_err, term_data, term_da, busy
  );
endinterface

// File: rtl/terminal_char_sender.sv
// Host-side transmitter for the terminal character port.
// Characters written by the host are queued in a small FIFO and sent one at a
// time using the DA/RDA handshake: term_data is set up for one cycle, term_da
// is raised, and the character is released when the terminal pulls term_rda
// low (or after TIMEOUT cycles without an acknowledge).
module terminal_char_sender #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  terminal_char_sender_if.slave   bus
);

  localparam int DATA_W = 7;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SETUP      = 2'd1,
    WAIT_ACK   = 2'd2,
    WAIT_READY = 2'd3
  } state_t;

  state_t            state;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;

  // term_rda synchronizer: rda_p0 is the metastability stage, rda_s is safe to use
  logic              rda_p0;
  logic              rda_s;

  // Handshake outputs and acknowledge timer
  logic [DATA_W-1:0] term_data_q;
  logic              term_da_q;
  logic              busy_q;
  logic [TW-1:0]     tmo_cnt;

  // Sticky error flags
  logic              overflow_q;
  logic              timeout_q;

  logic              full_w;
  logic              empty_w;
  logic              wr_ok;
  logic              pop;
  logic              ovf_evt;
  logic              tmo_hit;
  logic              tmo_evt;

  // full is judged on the registered occupancy, so a pop in the same cycle
  // cannot make room for a write that arrives while the FIFO is full.
  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);
  assign wr_ok   = bus.wr_en && !full_w;
  assign ovf_evt = bus.wr_en && full_w;
  assign pop     = (state == IDLE) && !empty_w && rda_s;
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));
  assign tmo_evt = (state == WAIT_ACK) && rda_s && tmo_hit;

  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.timeout_err = timeout_q;
  assign bus.term_data   = term_data_q;
  assign bus.term_da     = term_da_q;
  assign bus.busy        = busy_q;

  // Two-flop synchronizer for the asynchronous terminal ready line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rda_p0 <= 1'b0;
      rda_s  <= 1'b0;
    end else begin
      rda_p0 <= bus.term_rda;
      rda_s  <= rda_p0;
    end
  end

  // FIFO storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous write and pop leave count unchanged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a new event in the same cycle as err_clr wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      overflow_q <= ovf_evt | (overflow_q & ~bus.err_clr);
      timeout_q  <= tmo_evt | (timeout_q & ~bus.err_clr);
    end
  end

  // Handshake sequencer with registered term_data/term_da/busy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      term_data_q <= '0;
      term_da_q   <= 1'b0;
      busy_q      <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            term_data_q <= mem[rd_ptr];
            busy_q      <= 1'b1;
            state       <= SETUP;
          end
        end
        // term_data has been valid for one cycle; now raise the strobe
        SETUP: begin
          term_da_q <= 1'b1;
          tmo_cnt   <= '0;
          state     <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!rda_s) begin
            term_da_q <= 1'b0;
            state     <= WAIT_READY;
          end else if (tmo_hit) begin
            term_da_q <= 1'b0;
            state     <= WAIT_READY;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        // Terminal must return to ready before the next character is offered
        WAIT_READY: begin
          term_da_q <= 1'b0;
          if (rda_s) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          term_da_q <= 1'b0;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
